op_queue: RTL and testbench

- Buffers 4-bit op codes from the host/testbench side and issues them one per cycle to the op decoder (`dut`), which turns them into `write`/`source`.
- Sits directly upstream of the decoder; its `op_code` output wires straight to the decoder's `op_code` input.
- Holds its output under downstream stall, drives a defined NOP when empty, and flags dropped pushes.
- Replaces free-running, unsynchronised op_code stimulus with a registered, X-free source aligned to `clk`.

---
 rtl/op_pkg.sv | 13 +
 rtl/op_fifo_mem.sv | 48 ++++
 rtl/op_queue.sv | 92 +++++++++
 tb/tb_op_queue.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/op_pkg.sv
// Shared op code definitions for op_queue and the downstream op decoder.
package op_pkg;

  localparam int unsigned OP_W = 4;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_NOP     = 4'b0000;
  localparam op_t OP_WRITE_A = 4'b0001;
  localparam op_t OP_WRITE_B = 4'b0010;
  localparam op_t OP_READ_C  = 4'b0011;

endpackage

// File: rtl/op_fifo_mem.sv
// Circular op storage: DEPTH x OP_W memory with wrapping pointers and an occupancy count.
module op_fifo_mem
  import op_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  op_t                      i_wr_data,
  output op_t                      o_rd_data,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  op_t             r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_count   = r_count;

endmodule

// File: rtl/op_queue.sv
// Op issue queue feeding the op decoder; registered X-free op_code with stall hold and NOP fill.
// Build option: define OP_QUEUE_BYPASS_EN for a 1-edge empty-queue bypass path.
module op_queue
  import op_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter op_t         NOP_CODE = OP_NOP
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  op_t                      in_op,
  output logic                     in_ready,
  input  logic                     stall,
  output op_t                      op_code,
  output logic                     op_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          w_push;
  logic          w_issue;
  logic          w_bypass;
  logic          w_store;
  logic          w_empty;
  op_t           w_rd_data;
  logic [CW-1:0] w_count;

  op_t           r_op_code;
  logic          r_op_valid;
  logic          r_overflow;

  // Readiness comes from the registered count only; a same-cycle pop does not free a slot.
  assign in_ready = (w_count < CW'(DEPTH));
  assign w_empty  = (w_count == '0);
  assign w_push   = in_valid && in_ready;
  assign w_issue  = !stall && !w_empty;

`ifdef OP_QUEUE_BYPASS_EN
  assign w_bypass = w_push && w_empty && !stall;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_store = w_push && !w_bypass;

  op_fifo_mem #(
    .DEPTH(DEPTH)
  ) u_mem (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_store),
    .i_pop     (w_issue),
    .i_wr_data (in_op),
    .o_rd_data (w_rd_data),
    .o_count   (w_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_code  <= NOP_CODE;
      r_op_valid <= 1'b0;
    end else if (!stall) begin
      if (w_issue) begin
        r_op_code  <= w_rd_data;
        r_op_valid <= 1'b1;
      end else if (w_bypass) begin
        r_op_code  <= in_op;
        r_op_valid <= 1'b1;
      end else begin
        r_op_code  <= NOP_CODE;
        r_op_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (in_valid && !in_ready) begin
      r_overflow <= 1'b1;
    end
  end

  assign op_code  = r_op_code;
  assign op_valid = r_op_valid;
  assign count    = w_count;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_op_queue.sv
// Directed scoreboard bench for op_queue (DEPTH = 4), sampling 1 time unit after each rising edge.
module tb_op_queue;
  import op_pkg::*;

  localparam int unsigned DEPTH = 4;
`ifdef OP_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid;
  op_t        in_op;
  logic       in_ready;
  logic       stall;
  op_t        op_code;
  logic       op_valid;
  logic [2:0] count;
  logic       overflow;

  op_queue #(
    .DEPTH    (DEPTH),
    .NOP_CODE (OP_NOP)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_op    (in_op),
    .in_ready (in_ready),
    .stall    (stall),
    .op_code  (op_code),
    .op_valid (op_valid),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  op_t  sb[$];
  op_t  exp_op    = OP_NOP;
  logic exp_valid = 1'b0;
  logic exp_ovf   = 1'b0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".op_code"},  8'(op_code),  8'(exp_op));
    chk({tag, ".op_valid"}, 8'(op_valid), 8'(exp_valid));
    chk({tag, ".count"},    8'(count),    8'(sb.size()));
    chk({tag, ".in_ready"}, 8'(in_ready), 8'(sb.size() < DEPTH));
    chk({tag, ".overflow"}, 8'(overflow), 8'(exp_ovf));
  endtask

  // Drive one cycle, advance the reference model across the edge, then compare.
  task automatic cycle(input logic v, input op_t op, input logic st, input string tag);
    bit ready, push, issue, byp;
    in_valid = v;
    in_op    = op;
    stall    = st;
    ready = (sb.size() < DEPTH);
    push  = v && ready;
    issue = !st && (sb.size() > 0);
    byp   = BYP && push && (sb.size() == 0) && !st;
    if (v && !ready) exp_ovf = 1'b1;
    if (!st) begin
      if (issue) begin
        exp_op    = sb.pop_front();
        exp_valid = 1'b1;
      end else if (byp) begin
        exp_op    = op;
        exp_valid = 1'b1;
      end else begin
        exp_op    = OP_NOP;
        exp_valid = 1'b0;
      end
    end
    if (push && !byp) sb.push_back(op);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    in_valid = 1'b0;
    in_op    = OP_NOP;
    stall    = 1'b0;

    #1 rst = 1'b1;
    #1 check_all("in_reset");
    @(posedge clk);
    #1 check_all("in_reset_edge");
    #2 rst = 1'b0;

    repeat (5) cycle(1'b0, OP_NOP, 1'b0, "idle");

    cycle(1'b1, OP_WRITE_A, 1'b0, "stream");
    cycle(1'b1, OP_WRITE_B, 1'b0, "stream");
    cycle(1'b1, OP_READ_C,  1'b0, "stream");
    repeat (3) cycle(1'b0, OP_NOP, 1'b0, "stream_tail");

    // Put a real op on the output so the stall hold is visible.
    cycle(1'b1, OP_READ_C, 1'b0, "pre_stall");
    cycle(1'b0, OP_NOP,    1'b0, "pre_stall");
    cycle(1'b1, OP_WRITE_A, 1'b1, "fill");
    cycle(1'b1, OP_WRITE_B, 1'b1, "fill");
    cycle(1'b1, OP_READ_C,  1'b1, "fill");
    cycle(1'b1, OP_WRITE_B, 1'b1, "fill_full");
    cycle(1'b1, 4'hF,       1'b1, "overflow_push");
    cycle(1'b0, OP_NOP,     1'b1, "hold_full");
    repeat (5) cycle(1'b0, OP_NOP, 1'b0, "drain");

    for (int i = 0; i < 10; i++) cycle(1'b1, op_t'(i + 1), 1'b0, "continuous");
    repeat (2) cycle(1'b0, OP_NOP, 1'b0, "cont_drain");

    for (int i = 0; i < 8; i++) cycle(1'b1, op_t'(i + 7), (i == 3) || (i == 4), "stall_pulse");
    repeat (5) cycle(1'b0, OP_NOP, 1'b0, "pulse_drain");

    cycle(1'b1, OP_WRITE_A, 1'b1, "pre_rst");
    cycle(1'b1, OP_WRITE_B, 1'b1, "pre_rst");
    cycle(1'b1, OP_READ_C,  1'b1, "pre_rst");
    in_valid = 1'b0;
    stall    = 1'b0;
    #3 rst = 1'b1;
    sb.delete();
    exp_op    = OP_NOP;
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
    #1 check_all("async_rst");
    #2 rst = 1'b0;
    repeat (4) cycle(1'b0, OP_NOP, 1'b0, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
